sdram_port_arbiter: RTL and testbench

//  N-port Avalon-MM front end for the SDRAM controller slave in the RAM subsystem. Round-robin

---
 rtl/sdram_arb_pkg.sv | 16 +
 rtl/sdram_tag_fifo.sv | 74 +++++++
 rtl/sdram_port_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_sdram_port_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_arb_pkg.sv
// Shared definitions for the SDRAM port arbiter.
//   port_w()  : tag width needed to name one of n ports (at least one bit)
//   state_t   : command-register FSM state
package sdram_arb_pkg;

    function automatic int port_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // IDLE: command register empty. ISSUE: a command is presented to the controller.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } state_t;

endpackage

// File: rtl/sdram_tag_fifo.sv
// Synchronous FIFO holding the port tag of every read issued to the controller.
//   clk, srst  : clock and synchronous active-high reset
//   push       : write push_data at the tail
//   pop        : remove the head; ignored (and flagged on underflow) when empty
//   pop_data   : head tag, registered, valid the cycle after the pop
//   pop_valid  : pop_data carries a tag this cycle
//   underflow  : combinational, pop requested while empty
//   count      : entries currently held
module sdram_tag_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             pop_valid,
    output logic             underflow,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic [WIDTH-1:0] pop_data_reg;
    logic             pop_valid_reg;
    logic             empty;
    logic             do_pop;

    assign empty     = (count_reg == '0);
    assign do_pop    = pop && !empty;
    assign underflow = pop && empty;
    assign count     = count_reg;
    assign pop_data  = pop_data_reg;
    assign pop_valid = pop_valid_reg;

    // Storage and registered read port: no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= push_data;
        end
        if (do_pop) begin
            pop_data_reg <= mem[rd_ptr_reg];
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            pop_valid_reg <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            pop_valid_reg <= do_pop;
            case ({push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Round-robin Avalon-MM front end sharing one SDRAM controller port among
// NUM_PORTS masters. Reads are tagged with their port; returns are routed in
// issue order.
//   clk_clk, reset_reset      : clock, synchronous active-high reset
//   m_*                       : per-port packed master buses (port p at slice p)
//   m_waitrequest             : low only on the cycle a port's command is latched
//   m_readdata/m_readdatavalid: registered shared return data, one-hot owner
//   sdram_*                   : registered command to / return from the controller
//   err_underflow             : sticky, a return arrived with no read outstanding
module sdram_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int NUM_PORTS   = 4,
    parameter int ADDR_W      = 25,
    parameter int DATA_W      = 16,
    parameter int MAX_PENDING = 8,
    localparam int BE_W       = DATA_W / 8,
    localparam int PORT_W     = port_w(NUM_PORTS)
) (
    input  logic                        clk_clk,
    input  logic                        reset_reset,
    input  logic [NUM_PORTS*ADDR_W-1:0] m_address,
    input  logic [NUM_PORTS*BE_W-1:0]   m_byteenable_n,
    input  logic [NUM_PORTS*DATA_W-1:0] m_writedata,
    input  logic [NUM_PORTS-1:0]        m_read_n,
    input  logic [NUM_PORTS-1:0]        m_write_n,
    output logic [NUM_PORTS-1:0]        m_waitrequest,
    output logic [DATA_W-1:0]           m_readdata,
    output logic [NUM_PORTS-1:0]        m_readdatavalid,
    output logic [ADDR_W-1:0]           sdram_address,
    output logic [BE_W-1:0]             sdram_byteenable_n,
    output logic                        sdram_chipselect,
    output logic [DATA_W-1:0]           sdram_writedata,
    output logic                        sdram_read_n,
    output logic                        sdram_write_n,
    input  logic [DATA_W-1:0]           sdram_readdata,
    input  logic                        sdram_readdatavalid,
    input  logic                        sdram_waitrequest,
    output logic                        err_underflow
);

    localparam int CNT_W = $clog2(MAX_PENDING) + 1;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [BE_W-1:0]   be_n;
        logic [DATA_W-1:0] wdata;
        logic              rd;
        logic              wr;
    } cmd_t;

    logic clk;
    logic srst;
    assign clk  = clk_clk;
    assign srst = reset_reset;

    state_t              state_reg, state_next;
    cmd_t                cmd_reg, cmd_next;
    logic                cs_reg, cs_next;
    logic [PORT_W-1:0]   rr_reg, rr_next;
    logic [DATA_W-1:0]   readdata_reg;
    logic                err_reg;

    cmd_t                port_cmd [NUM_PORTS];
    logic [NUM_PORTS-1:0] elig;
    logic [NUM_PORTS-1:0] grant;
    logic                free;
    logic                found;
    logic [PORT_W-1:0]   winner;
    logic                credit;

    logic [PORT_W-1:0]   tag_head;
    logic                tag_valid;
    logic                tag_underflow;
    logic [CNT_W-1:0]    tag_count;

    // Credit is judged on the registered count: a return this cycle frees a
    // slot only from the next cycle on.
    assign credit = (tag_count < CNT_W'(MAX_PENDING));
    assign free   = (state_reg == ST_IDLE) || !sdram_waitrequest;

    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
            assign port_cmd[gi].addr  = m_address[gi*ADDR_W +: ADDR_W];
            assign port_cmd[gi].be_n  = m_byteenable_n[gi*BE_W +: BE_W];
            assign port_cmd[gi].wdata = m_writedata[gi*DATA_W +: DATA_W];
            // A port asserting both strobes is treated as writing.
            assign port_cmd[gi].wr    = !m_write_n[gi];
            assign port_cmd[gi].rd    = !m_read_n[gi] && m_write_n[gi];
            assign elig[gi]           = port_cmd[gi].wr || (port_cmd[gi].rd && credit);
            assign grant[gi]          = !srst && free && found && (winner == PORT_W'(gi));
            assign m_waitrequest[gi]  = !grant[gi];
            assign m_readdatavalid[gi] = tag_valid && (tag_head == PORT_W'(gi));
        end
    endgenerate

    // Round-robin scan starting just after the last winner.
    always_comb begin
        int idx;
        found  = 1'b0;
        winner = rr_reg;
        idx    = 0;
        for (int i = 1; i <= NUM_PORTS; i++) begin
            idx = int'(rr_reg) + i;
            if (idx >= NUM_PORTS) begin
                idx = idx - NUM_PORTS;
            end
            if (!found && elig[PORT_W'(idx)]) begin
                found  = 1'b1;
                winner = PORT_W'(idx);
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        cmd_next   = cmd_reg;
        cs_next    = cs_reg;
        rr_next    = rr_reg;
        if (free) begin
            if (found) begin
                cmd_next   = port_cmd[winner];
                cs_next    = 1'b1;
                rr_next    = winner;
                state_next = ST_ISSUE;
            end else begin
                cmd_next.rd = 1'b0;
                cmd_next.wr = 1'b0;
                cs_next     = 1'b0;
                state_next  = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state_reg    <= ST_IDLE;
            cmd_reg      <= '0;
            cmd_reg.be_n <= '1;
            cs_reg       <= 1'b0;
            rr_reg       <= '0;
            readdata_reg <= '0;
            err_reg      <= 1'b0;
        end else begin
            state_reg <= state_next;
            cmd_reg   <= cmd_next;
            cs_reg    <= cs_next;
            rr_reg    <= rr_next;
            if (sdram_readdatavalid && !tag_underflow) begin
                readdata_reg <= sdram_readdata;
            end
            if (tag_underflow) begin
                err_reg <= 1'b1;
            end
        end
    end

    sdram_tag_fifo #(
        .WIDTH (PORT_W),
        .DEPTH (MAX_PENDING)
    ) u_tag_fifo (
        .clk       (clk),
        .srst      (srst),
        .push      (free && found && port_cmd[winner].rd),
        .push_data (winner),
        .pop       (sdram_readdatavalid),
        .pop_data  (tag_head),
        .pop_valid (tag_valid),
        .underflow (tag_underflow),
        .count     (tag_count)
    );

    assign sdram_address      = cmd_reg.addr;
    assign sdram_byteenable_n = cmd_reg.be_n;
    assign sdram_writedata    = cmd_reg.wdata;
    assign sdram_read_n       = !cmd_reg.rd;
    assign sdram_write_n      = !cmd_reg.wr;
    assign sdram_chipselect   = cs_reg;
    assign m_readdata         = readdata_reg;
    assign err_underflow      = err_reg;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
module tb_sdram_port_arbiter;

    localparam int NP = 4;
    localparam int AW = 25;
    localparam int DW = 16;
    localparam int BW = DW / 8;

    logic              clk_clk = 1'b0;
    logic              reset_reset;
    logic [NP*AW-1:0]  m_address;
    logic [NP*BW-1:0]  m_byteenable_n;
    logic [NP*DW-1:0]  m_writedata;
    logic [NP-1:0]     m_read_n;
    logic [NP-1:0]     m_write_n;
    logic [NP-1:0]     m_waitrequest;
    logic [DW-1:0]     m_readdata;
    logic [NP-1:0]     m_readdatavalid;
    logic [AW-1:0]     sdram_address;
    logic [BW-1:0]     sdram_byteenable_n;
    logic              sdram_chipselect;
    logic [DW-1:0]     sdram_writedata;
    logic              sdram_read_n;
    logic              sdram_write_n;
    logic [DW-1:0]     sdram_readdata;
    logic              sdram_readdatavalid;
    logic              sdram_waitrequest;
    logic              err_underflow;

    sdram_port_arbiter #(
        .NUM_PORTS   (NP),
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .MAX_PENDING (8)
    ) dut (
        .clk_clk             (clk_clk),
        .reset_reset         (reset_reset),
        .m_address           (m_address),
        .m_byteenable_n      (m_byteenable_n),
        .m_writedata         (m_writedata),
        .m_read_n            (m_read_n),
        .m_write_n           (m_write_n),
        .m_waitrequest       (m_waitrequest),
        .m_readdata          (m_readdata),
        .m_readdatavalid     (m_readdatavalid),
        .sdram_address       (sdram_address),
        .sdram_byteenable_n  (sdram_byteenable_n),
        .sdram_chipselect    (sdram_chipselect),
        .sdram_writedata     (sdram_writedata),
        .sdram_read_n        (sdram_read_n),
        .sdram_write_n       (sdram_write_n),
        .sdram_readdata      (sdram_readdata),
        .sdram_readdatavalid (sdram_readdatavalid),
        .sdram_waitrequest   (sdram_waitrequest),
        .err_underflow       (err_underflow)
    );

    always #5 clk_clk = ~clk_clk;

    int pass_cnt  = 0;
    int check_cnt = 0;

    // Expected read returns: {one-hot port, data}, pushed when the return is driven.
    logic [NP+DW-1:0] exp_q [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        check_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Advance one clock, sample 1 time unit after the edge and score any return.
    task automatic tick();
        logic [NP+DW-1:0] e;
        @(posedge clk_clk);
        #1;
        if (m_readdatavalid !== '0) begin
            if (exp_q.size() == 0) begin
                chk("rdv_unexpected", 64'(m_readdatavalid), 64'(0));
            end else begin
                e = exp_q.pop_front();
                $display("read return: valid=%b data=0x%h", m_readdatavalid, m_readdata);
                chk("rdv_port", 64'(m_readdatavalid), 64'(e[NP+DW-1:DW]));
                chk("rdv_data", 64'(m_readdata), 64'(e[DW-1:0]));
            end
        end
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        m_read_n            = '1;
        m_write_n           = '1;
        sdram_readdatavalid = 1'b0;
        sdram_waitrequest   = 1'b0;
        sdram_readdata      = '0;
    endtask

    task automatic do_reset();
        reset_reset = 1'b1;
        idle_inputs();
        tick();
        tick();
        reset_reset = 1'b0;
    endtask

    task automatic drive_return(input logic [DW-1:0] data, input logic [NP-1:0] owner_oh);
        sdram_readdatavalid = 1'b1;
        sdram_readdata      = data;
        exp_q.push_back({owner_oh, data});
        tick();
        sdram_readdatavalid = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] wdata [NP];
        logic [NP-1:0] exp_wait;
        int p;

        m_address      = '0;
        m_byteenable_n = '0;
        m_writedata    = '0;
        for (int i = 0; i < NP; i++) begin
            wdata[i] = DW'(16'hC000 + i * 16'h0111);
            m_writedata[i*DW +: DW] = wdata[i];
            m_address[i*AW +: AW]   = AW'(25'h10_0000 + i);
        end

        // Reset state; a request during reset must not be acknowledged.
        reset_reset = 1'b1;
        idle_inputs();
        m_write_n[0] = 1'b0;
        tick();
        settle();
        chk("rst_waitreq", 64'(m_waitrequest), 64'(4'hF));
        tick();
        reset_reset = 1'b0;
        m_write_n   = '1;
        chk("rst_cs", 64'(sdram_chipselect), 64'(0));
        chk("rst_read_n", 64'(sdram_read_n), 64'(1));
        chk("rst_write_n", 64'(sdram_write_n), 64'(1));
        chk("rst_addr", 64'(sdram_address), 64'(0));
        chk("rst_wdata", 64'(sdram_writedata), 64'(0));
        chk("rst_be_n", 64'(sdram_byteenable_n), 64'(2'b11));
        chk("rst_rdv", 64'(m_readdatavalid), 64'(0));
        chk("rst_rdata", 64'(m_readdata), 64'(0));
        chk("rst_err", 64'(err_underflow), 64'(0));

        // 1: single read from port 2, data returned three cycles later.
        m_address[2*AW +: AW] = 25'h000_0100;
        m_read_n[2] = 1'b0;
        settle();
        chk("t1_grant", 64'(m_waitrequest), 64'(4'b1011));
        tick();
        chk("t1_cs", 64'(sdram_chipselect), 64'(1));
        chk("t1_read_n", 64'(sdram_read_n), 64'(0));
        chk("t1_addr", 64'(sdram_address), 64'(25'h000_0100));
        m_read_n[2] = 1'b1;
        settle();
        chk("t1_wait_after", 64'(m_waitrequest), 64'(4'hF));
        tick();
        chk("t1_cs_drop", 64'(sdram_chipselect), 64'(0));
        tick();
        drive_return(16'hBEEF, 4'b0100);
        chk("t1_sb_empty", 64'(exp_q.size()), 64'(0));

        // 2: all ports write continuously -> 1,2,3,0,... one grant per cycle.
        do_reset();
        m_write_n = '0;
        for (int k = 0; k < 8; k++) begin
            p = (k + 1) % NP;
            exp_wait = ~(NP'(1) << p);
            settle();
            chk("t2_grant", 64'(m_waitrequest), 64'(exp_wait));
            tick();
            chk("t2_wdata", 64'(sdram_writedata), 64'(wdata[p]));
            chk("t2_cs", 64'(sdram_chipselect), 64'(1));
            chk("t2_write_n", 64'(sdram_write_n), 64'(0));
        end
        m_write_n = '1;
        tick();
        chk("t2_cs_drop", 64'(sdram_chipselect), 64'(0));

        // 3: controller stalls a port 0 write for five cycles.
        m_writedata[0 +: DW]   = 16'h1234;
        m_address[0 +: AW]     = 25'h000_0055;
        m_byteenable_n[0 +: BW] = 2'b01;
        m_write_n[0] = 1'b0;
        settle();
        chk("t3_grant0", 64'(m_waitrequest), 64'(4'b1110));
        tick();
        m_write_n         = 4'b0101;
        sdram_waitrequest = 1'b1;
        for (int k = 0; k < 5; k++) begin
            settle();
            chk("t3_wait_hold", 64'(m_waitrequest), 64'(4'hF));
            tick();
            chk("t3_cs", 64'(sdram_chipselect), 64'(1));
            chk("t3_addr", 64'(sdram_address), 64'(25'h000_0055));
            chk("t3_wdata", 64'(sdram_writedata), 64'(16'h1234));
            chk("t3_be_n", 64'(sdram_byteenable_n), 64'(2'b01));
            chk("t3_write_n", 64'(sdram_write_n), 64'(0));
        end
        sdram_waitrequest = 1'b0;
        settle();
        chk("t3_grant1", 64'(m_waitrequest), 64'(4'b1101));
        tick();
        chk("t3_wdata1", 64'(sdram_writedata), 64'(wdata[1]));
        m_write_n = '1;
        tick();
        chk("t3_cs_drop", 64'(sdram_chipselect), 64'(0));

        // 4: read credit limit.
        do_reset();
        m_read_n[1] = 1'b0;
        for (int k = 0; k < 8; k++) begin
            settle();
            chk("t4_rd_grant", 64'(m_waitrequest), 64'(4'b1101));
            tick();
        end
        settle();
        chk("t4_stall", 64'(m_waitrequest), 64'(4'hF));
        tick();
        settle();
        chk("t4_stall2", 64'(m_waitrequest), 64'(4'hF));
        m_write_n[2] = 1'b0;
        settle();
        chk("t4_wr_grant", 64'(m_waitrequest), 64'(4'b1011));
        tick();
        chk("t4_wr_issue", 64'(sdram_write_n), 64'(0));
        chk("t4_wr_not_rd", 64'(sdram_read_n), 64'(1));
        m_write_n[2] = 1'b1;
        sdram_readdatavalid = 1'b1;
        sdram_readdata      = 16'h0D01;
        exp_q.push_back({4'b0010, 16'h0D01});
        settle();
        chk("t4_no_same_cycle_credit", 64'(m_waitrequest), 64'(4'hF));
        tick();
        sdram_readdatavalid = 1'b0;
        settle();
        chk("t4_9th_grant", 64'(m_waitrequest), 64'(4'b1101));
        tick();
        chk("t4_9th_issue", 64'(sdram_read_n), 64'(0));
        chk("t4_9th_cs", 64'(sdram_chipselect), 64'(1));
        m_read_n[1] = 1'b1;
        for (int k = 0; k < 8; k++) begin
            drive_return(DW'(16'h0D10 + k), 4'b0010);
        end
        tick();
        chk("t4_sb_empty", 64'(exp_q.size()), 64'(0));
        chk("t4_no_err", 64'(err_underflow), 64'(0));

        // 5: interleaved reads 3,0,3 routed back in issue order.
        m_read_n[3] = 1'b0;
        settle();
        chk("t5_grant3a", 64'(m_waitrequest), 64'(4'b0111));
        tick();
        m_read_n = '1;
        m_read_n[0] = 1'b0;
        settle();
        chk("t5_grant0", 64'(m_waitrequest), 64'(4'b1110));
        tick();
        m_read_n = '1;
        m_read_n[3] = 1'b0;
        settle();
        chk("t5_grant3b", 64'(m_waitrequest), 64'(4'b0111));
        tick();
        m_read_n = '1;
        drive_return(16'h000A, 4'b1000);
        drive_return(16'h000B, 4'b0001);
        drive_return(16'h000C, 4'b1000);
        tick();
        chk("t5_sb_empty", 64'(exp_q.size()), 64'(0));

        // 6: return with no read outstanding, then reset with reads pending.
        sdram_readdatavalid = 1'b1;
        sdram_readdata      = 16'h0077;
        tick();
        sdram_readdatavalid = 1'b0;
        chk("t6_no_rdv", 64'(m_readdatavalid), 64'(0));
        chk("t6_err_set", 64'(err_underflow), 64'(1));
        tick();
        tick();
        tick();
        chk("t6_err_sticky", 64'(err_underflow), 64'(1));
        m_read_n[0] = 1'b0;
        tick();
        m_read_n = 4'b1101;
        tick();
        m_read_n = '1;
        chk("t6_cs_pending", 64'(sdram_chipselect), 64'(1));
        reset_reset  = 1'b1;
        m_write_n[2] = 1'b0;
        settle();
        chk("t6_rst_waitreq", 64'(m_waitrequest), 64'(4'hF));
        tick();
        reset_reset = 1'b0;
        m_write_n   = '1;
        chk("t6_rst_cs", 64'(sdram_chipselect), 64'(0));
        chk("t6_rst_err", 64'(err_underflow), 64'(0));
        tick();
        sdram_readdatavalid = 1'b1;
        sdram_readdata      = 16'h0099;
        tick();
        sdram_readdatavalid = 1'b0;
        chk("t6_late_no_rdv", 64'(m_readdatavalid), 64'(0));
        chk("t6_late_err", 64'(err_underflow), 64'(1));
        chk("final_sb_empty", 64'(exp_q.size()), 64'(0));

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
